// File: rtl/tt_eqv_sweeper.sv
// tt_eqv_sweeper
//   Exhaustive sequential equivalence checker for a small logic cell. On start,
//   latches an expected truth table, then walks every input vector in ascending
//   order, holding each for SETTLE cycles before sampling the cell's response.
//   Reports pass/fail, the number of mismatching vectors and the lowest failing
//   vector.
//
// Parameters
//   N_IN    cell input count (1..16); truth table is 2^N_IN bits
//   SETTLE  cycles each vector is held before sampling (>= 1)
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           begin a sweep (accepted when busy = 0)
//   abort           cancel a running sweep (ignored when busy = 0)
//   tt_in           expected truth table, bit v = response for vector v
//   dut_resp        output of the cell under test
//   vec_out         input vector driven to the cell
//   busy            sweep in progress
//   done            one-cycle pulse at sweep completion
//   pass            last completed sweep had no mismatches
//   mismatch_cnt    mismatching vector count (holds up to 2^N_IN)
//   first_fail      lowest mismatching vector
//   fail_valid      first_fail is meaningful
module tt_eqv_sweeper #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [(1<<N_IN)-1:0] tt_in,
    input  logic                 dut_resp,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail,
    output logic                 fail_valid
);

    localparam int unsigned TT_W = 1 << N_IN;
    localparam int unsigned CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE - 1);
    localparam logic [CW-1:0]   CNT_STEP = CW'(1);
    localparam logic [N_IN-1:0] VEC_LAST = '1;
    localparam logic [N_IN-1:0] VEC_STEP = N_IN'(1);
    localparam logic [N_IN:0]   MC_STEP  = (N_IN+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t          state;
    logic [TT_W-1:0] tt_q;
    logic [CW-1:0]   settle_cnt;
    logic            miss;

    assign miss = (dut_resp != tt_q[vec_out]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tt_q         <= '0;
            settle_cnt   <= '0;
            vec_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_valid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        state        <= SWEEP;
                        busy         <= 1'b1;
                        tt_q         <= tt_in;
                        vec_out      <= '0;
                        settle_cnt   <= RELOAD;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        fail_valid   <= 1'b0;
                        pass         <= 1'b0;
                    end
                end

                SWEEP: begin
                    if (abort) begin
                        // Abort wins over a coincident sample: that vector is not counted.
                        state   <= IDLE;
                        busy    <= 1'b0;
                        vec_out <= '0;
                    end else if (settle_cnt == '0) begin
                        if (miss) begin
                            mismatch_cnt <= mismatch_cnt + MC_STEP;
                            if (!fail_valid) begin
                                first_fail <= vec_out;
                                fail_valid <= 1'b1;
                            end
                        end
                        settle_cnt <= RELOAD;
                        if (vec_out == VEC_LAST) begin
                            // Final count includes this last sample, so fold it into pass.
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            vec_out <= '0;
                            pass    <= (mismatch_cnt == '0) && !miss;
                        end else begin
                            vec_out <= vec_out + VEC_STEP;
                        end
                    end else begin
                        settle_cnt <= settle_cnt - CNT_STEP;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_eqv_sweeper.sv
// tb_tt_eqv_sweeper
//   Table-driven bench for tt_eqv_sweeper. Instance a uses SETTLE=1, instance b
//   uses SETTLE=3. Each instance drives a bench-side cell model that is either
//   combinational or a two-stage pipeline of a chosen truth table. Directed
//   sequences cover abort, asynchronous reset mid-sweep and held start.
module tb_tt_eqv_sweeper;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start_a, abort_a, resp_a, busy_a, done_a, pass_a, fv_a;
    logic [15:0] tt_a;
    logic [3:0]  vec_a, ff_a;
    logic [4:0]  mc_a;

    logic        start_b, abort_b, resp_b, busy_b, done_b, pass_b, fv_b;
    logic [15:0] tt_b;
    logic [3:0]  vec_b, ff_b;
    logic [4:0]  mc_b;

    // Cell models: table of the cell under test, optional two register stages.
    logic [15:0] mdl_a = '0, mdl_b = '0;
    logic        pipe_a = 1'b0, pipe_b = 1'b0;
    logic        p1_a = 1'b0, p2_a = 1'b0, p1_b = 1'b0, p2_b = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        p1_a <= mdl_a[vec_a];
        p2_a <= p1_a;
        p1_b <= mdl_b[vec_b];
        p2_b <= p1_b;
    end

    assign resp_a = pipe_a ? p2_a : mdl_a[vec_a];
    assign resp_b = pipe_b ? p2_b : mdl_b[vec_b];

    tt_eqv_sweeper #(.N_IN(4), .SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .tt_in(tt_a), .dut_resp(resp_a), .vec_out(vec_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .mismatch_cnt(mc_a),
        .first_fail(ff_a), .fail_valid(fv_a)
    );

    tt_eqv_sweeper #(.N_IN(4), .SETTLE(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .tt_in(tt_b), .dut_resp(resp_b), .vec_out(vec_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .mismatch_cnt(mc_b),
        .first_fail(ff_b), .fail_valid(fv_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Snapshot of one instance's outputs.
    function automatic int o_busy(input int w); return w != 0 ? int'(busy_b) : int'(busy_a); endfunction
    function automatic int o_done(input int w); return w != 0 ? int'(done_b) : int'(done_a); endfunction
    function automatic int o_pass(input int w); return w != 0 ? int'(pass_b) : int'(pass_a); endfunction
    function automatic int o_mc(input int w);   return w != 0 ? int'(mc_b)   : int'(mc_a);   endfunction
    function automatic int o_ff(input int w);   return w != 0 ? int'(ff_b)   : int'(ff_a);   endfunction
    function automatic int o_fv(input int w);   return w != 0 ? int'(fv_b)   : int'(fv_a);   endfunction
    function automatic int o_vec(input int w);  return w != 0 ? int'(vec_b)  : int'(vec_a);  endfunction

    // Pulse start for one cycle, scramble tt_in afterwards, and return the
    // number of cycles from the acceptance edge until done is seen (-1 on timeout).
    task automatic run_sweep(input int w, input logic [15:0] tt, input logic [15:0] mdl,
                             input logic pipe, output int lat);
        @(negedge clk);
        if (w != 0) begin tt_b = tt; mdl_b = mdl; pipe_b = pipe; start_b = 1'b1; end
        else        begin tt_a = tt; mdl_a = mdl; pipe_a = pipe; start_a = 1'b1; end
        @(negedge clk);
        if (w != 0) begin start_b = 1'b0; tt_b = ~tt; end
        else        begin start_a = 1'b0; tt_a = ~tt; end
        check("accept_busy", o_busy(w), 1);
        check("accept_vec", o_vec(w), 0);
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (o_done(w) != 0) begin
                lat = k;
                break;
            end
        end
    endtask

    typedef struct {
        int          inst;
        logic        pipe;
        logic [15:0] tt;
        logic [15:0] mdl;
        int          lat;
        int          pass;
        int          mc;
        int          ff;
        int          fv;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int lat;

        tbl[0] = '{0, 1'b0, 16'h9BF5, 16'h9BF5, 16, 1, 0,  0,  0};
        tbl[1] = '{0, 1'b0, 16'h9BF5, 16'h9BF4, 16, 0, 1,  0,  1};
        tbl[2] = '{0, 1'b0, 16'h9BF5, 16'h1BF4, 16, 0, 2,  0,  1};
        tbl[3] = '{0, 1'b0, 16'h9BF5, 16'h9BF1, 16, 0, 1,  2,  1};
        tbl[4] = '{0, 1'b0, 16'h9BF5, 16'h1BF5, 16, 0, 1,  15, 1};
        tbl[5] = '{0, 1'b0, 16'h9BF5, 16'h9B05, 16, 0, 4,  4,  1};
        tbl[6] = '{0, 1'b0, 16'h9BF5, 16'h640A, 16, 0, 16, 0,  1};
        tbl[7] = '{0, 1'b0, 16'h0000, 16'h0000, 16, 1, 0,  0,  0};
        tbl[8] = '{1, 1'b1, 16'h9BF5, 16'h9BF5, 48, 1, 0,  0,  0};

        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; tt_a = '0;
        start_b = 1'b0; abort_b = 1'b0; tt_b = '0;

        repeat (2) @(negedge clk);
        check("rst_vec", int'(vec_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_pass", int'(pass_a), 0);
        check("rst_mc", int'(mc_a), 0);
        check("rst_ff", int'(ff_a), 0);
        check("rst_fv", int'(fv_a), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven sweeps.
        foreach (tbl[i]) begin
            run_sweep(tbl[i].inst, tbl[i].tt, tbl[i].mdl, tbl[i].pipe, lat);
            check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("v%0d_busy_in_done", i), o_busy(tbl[i].inst), 0);
            check($sformatf("v%0d_pass", i), o_pass(tbl[i].inst), tbl[i].pass);
            check($sformatf("v%0d_mc", i), o_mc(tbl[i].inst), tbl[i].mc);
            check($sformatf("v%0d_ff", i), o_ff(tbl[i].inst), tbl[i].ff);
            check($sformatf("v%0d_fv", i), o_fv(tbl[i].inst), tbl[i].fv);
            check($sformatf("v%0d_vec_done", i), o_vec(tbl[i].inst), 0);
            repeat (3) @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), o_done(tbl[i].inst), 0);
            check($sformatf("v%0d_pass_hold", i), o_pass(tbl[i].inst), tbl[i].pass);
            check($sformatf("v%0d_mc_hold", i), o_mc(tbl[i].inst), tbl[i].mc);
        end

        // Two-stage cell with SETTLE=1 samples stale responses.
        run_sweep(0, 16'h9BF5, 16'h9BF5, 1'b1, lat);
        check("short_settle_latency", lat, 16);
        check("short_settle_pass", int'(pass_a), 0);
        check("short_settle_mc_nonzero", int'(mc_a > 5'd0), 1);
        pipe_a = 1'b0;
        repeat (2) @(negedge clk);

        // Abort at vector 5, cell wrong at vector 2.
        begin
            int seen_done;
            @(negedge clk);
            tt_a = 16'h9BF5; mdl_a = 16'h9BF1; start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            for (int k = 0; k < 100 && vec_a != 4'd5; k++) @(negedge clk);
            check("abort_reach_vec5", int'(vec_a), 5);
            abort_a = 1'b1;
            @(negedge clk);
            abort_a = 1'b0;
            check("abort_busy", int'(busy_a), 0);
            check("abort_done", int'(done_a), 0);
            check("abort_vec", int'(vec_a), 0);
            check("abort_mc", int'(mc_a), 1);
            check("abort_ff", int'(ff_a), 2);
            check("abort_fv", int'(fv_a), 1);
            check("abort_pass", int'(pass_a), 0);
            seen_done = 0;
            repeat (20) begin
                @(negedge clk);
                if (done_a) seen_done = 1;
            end
            check("abort_no_done", seen_done, 0);
            check("abort_idle", int'(busy_a), 0);
        end

        // Asynchronous reset mid-sweep at vector 9.
        @(negedge clk);
        tt_a = 16'h9BF5; mdl_a = 16'h9BF4; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 100 && vec_a != 4'd9; k++) @(negedge clk);
        check("rstmid_reach_vec9", int'(vec_a), 9);
        check("rstmid_fv_before", int'(fv_a), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_vec", int'(vec_a), 0);
        check("rstmid_busy", int'(busy_a), 0);
        check("rstmid_mc", int'(mc_a), 0);
        check("rstmid_ff", int'(ff_a), 0);
        check("rstmid_fv", int'(fv_a), 0);
        check("rstmid_pass", int'(pass_a), 0);
        check("rstmid_done", int'(done_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rstmid_wait_idle", int'(busy_a), 0);
        run_sweep(0, 16'h9BF5, 16'h9BF5, 1'b0, lat);
        check("rstmid_resweep_latency", lat, 16);
        check("rstmid_resweep_pass", int'(pass_a), 1);
        repeat (2) @(negedge clk);

        // start held high: ignored during SWEEP, re-accepted in the DONE cycle.
        @(negedge clk);
        tt_a = 16'h9BF5; mdl_a = 16'h9BF5; start_a = 1'b1;
        @(negedge clk);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done_a) begin
                lat = k;
                break;
            end
        end
        check("hold_latency", lat, 16);
        check("hold_pass", int'(pass_a), 1);
        @(negedge clk);
        start_a = 1'b0;
        check("hold_restart_busy", int'(busy_a), 1);
        check("hold_restart_vec", int'(vec_a), 0);
        check("hold_restart_done", int'(done_a), 0);
        check("hold_restart_pass_clear", int'(pass_a), 0);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done_a) begin
                lat = k;
                break;
            end
        end
        check("hold_second_latency", lat, 16);
        check("hold_second_pass", int'(pass_a), 1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
